// File: rtl/timer_ctrl_if.sv
// timer_ctrl_if: single-cycle register bus between a host and timer_ctrl.
interface timer_ctrl_if;
    logic        cs;
    logic        we;
    logic [7:0]  address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (output cs, we, address, write_data, input read_data, ready);
    modport slave  (input cs, we, address, write_data, output read_data, ready);
endinterface

// File: rtl/timer_ctrl.sv
// timer_ctrl: register front-end for a timer core; start/stop pulses, expiry flag, irq.
module timer_ctrl #(
    parameter logic [31:0] NAME0   = 32'h74696d65,
    parameter logic [31:0] NAME1   = 32'h72202020,
    parameter logic [31:0] VERSION = 32'h00000001
) (
    input  logic         clk,
    input  logic         reset_n,
    timer_ctrl_if.slave  bus,
    output logic         irq,
    output logic [31:0]  prescaler_init,
    output logic [31:0]  timer_init,
    output logic         start,
    output logic         stop,
    input  logic [31:0]  curr_timer,
    input  logic         running
);
    logic        expired_reg, irq_en_reg, running_prev_reg, stop_prev_reg;
    logic        rd, ctrl_wr, status_wr, pre_wr, tim_wr, irqen_wr;
    logic        do_start, do_stop, expire_set;
    logic [31:0] rd_mux;

    always_comb begin
        rd        = bus.cs && !bus.we;
        ctrl_wr   = bus.cs && bus.we && bus.address == 8'h08;
        status_wr = bus.cs && bus.we && bus.address == 8'h09;
        pre_wr    = bus.cs && bus.we && bus.address == 8'h0a;
        tim_wr    = bus.cs && bus.we && bus.address == 8'h0b;
        irqen_wr  = bus.cs && bus.we && bus.address == 8'h0c;
        do_start  = ctrl_wr && bus.write_data[0] && !bus.write_data[1] && !running;
        do_stop   = ctrl_wr && bus.write_data[1] && running;
        // a fall of running that follows our own stop pulse is not an expiry
        expire_set = running_prev_reg && !running && !stop_prev_reg && !stop;
        rd_mux = '0;
        case (bus.address)
            8'h00: rd_mux = NAME0;
            8'h01: rd_mux = NAME1;
            8'h02: rd_mux = VERSION;
            8'h09: rd_mux = {30'h0, expired_reg, running};
            8'h0a: rd_mux = prescaler_init;
            8'h0b: rd_mux = running ? curr_timer : timer_init;
            8'h0c: rd_mux = {31'h0, irq_en_reg};
            default: rd_mux = '0;
        endcase
        irq = expired_reg && irq_en_reg;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.read_data    <= '0;
            bus.ready        <= 1'b0;
            prescaler_init   <= '0;
            timer_init       <= '0;
            start            <= 1'b0;
            stop             <= 1'b0;
            expired_reg      <= 1'b0;
            irq_en_reg       <= 1'b0;
            running_prev_reg <= 1'b0;
            stop_prev_reg    <= 1'b0;
        end else begin
            bus.ready        <= bus.cs;
            start            <= do_start;
            stop             <= do_stop;
            stop_prev_reg    <= stop;
            running_prev_reg <= running;
            if (rd) bus.read_data <= rd_mux;
            if (pre_wr && !running) prescaler_init <= bus.write_data;
            if (tim_wr && !running) timer_init <= bus.write_data;
            if (irqen_wr) irq_en_reg <= bus.write_data[0];
            if (expire_set) expired_reg <= 1'b1;
            else if (do_start || (status_wr && bus.write_data[1])) expired_reg <= 1'b0;
        end
    end
endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: table-driven register checks plus expiry, irq and reset sequences.
module tb_timer_ctrl;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        irq, start, stop, running;
    logic [31:0] prescaler_init, timer_init, curr_timer;
    int          passed = 0;
    int          total = 0;

    timer_ctrl_if bus();

    timer_ctrl dut (
        .clk(clk), .reset_n(reset_n), .bus(bus), .irq(irq),
        .prescaler_init(prescaler_init), .timer_init(timer_init),
        .start(start), .stop(stop), .curr_timer(curr_timer), .running(running)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic        run;
        logic [31:0] cur;
        logic [31:0] rd;
        logic        st;
        logic        sp;
        logic [31:0] pre;
        logic [31:0] tim;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    task automatic access(input logic w, input logic [7:0] a, input logic [31:0] d,
                          input logic run, input logic [31:0] cur);
        @(negedge clk);
        bus.cs = 1'b1; bus.we = w; bus.address = a; bus.write_data = d;
        running = run; curr_timer = cur;
        @(posedge clk); #1;
    endtask

    task automatic drop();
        @(negedge clk);
        bus.cs = 1'b0; bus.we = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 8'h00, 32'h0, 1'b0, 32'h0, 32'h74696d65, 1'b0, 1'b0, 32'h0, 32'h0};
        vecs[1]  = '{1'b0, 8'h01, 32'h0, 1'b0, 32'h0, 32'h72202020, 1'b0, 1'b0, 32'h0, 32'h0};
        vecs[2]  = '{1'b0, 8'h02, 32'h0, 1'b0, 32'h0, 32'h00000001, 1'b0, 1'b0, 32'h0, 32'h0};
        vecs[3]  = '{1'b0, 8'h05, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0};
        vecs[4]  = '{1'b0, 8'h08, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0};
        vecs[5]  = '{1'b1, 8'h0a, 32'h3, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h3, 32'h0};
        vecs[6]  = '{1'b1, 8'h0b, 32'h5, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h3, 32'h5};
        vecs[7]  = '{1'b0, 8'h0a, 32'h0, 1'b0, 32'h0, 32'h3, 1'b0, 1'b0, 32'h3, 32'h5};
        vecs[8]  = '{1'b0, 8'h0b, 32'h0, 1'b0, 32'h0, 32'h5, 1'b0, 1'b0, 32'h3, 32'h5};
        vecs[9]  = '{1'b1, 8'h0c, 32'h1, 1'b0, 32'h0, 32'h5, 1'b0, 1'b0, 32'h3, 32'h5};
        vecs[10] = '{1'b0, 8'h0c, 32'h0, 1'b0, 32'h0, 32'h1, 1'b0, 1'b0, 32'h3, 32'h5};
        vecs[11] = '{1'b1, 8'h08, 32'h1, 1'b0, 32'h0, 32'h1, 1'b1, 1'b0, 32'h3, 32'h5};
        vecs[12] = '{1'b1, 8'h08, 32'h3, 1'b0, 32'h0, 32'h1, 1'b0, 1'b0, 32'h3, 32'h5};
        vecs[13] = '{1'b1, 8'h08, 32'h1, 1'b1, 32'h7, 32'h1, 1'b0, 1'b0, 32'h3, 32'h5};
        vecs[14] = '{1'b1, 8'h0b, 32'h9, 1'b1, 32'h7, 32'h1, 1'b0, 1'b0, 32'h3, 32'h5};
        vecs[15] = '{1'b0, 8'h0b, 32'h0, 1'b1, 32'h7, 32'h7, 1'b0, 1'b0, 32'h3, 32'h5};
        vecs[16] = '{1'b1, 8'h0a, 32'h4, 1'b1, 32'h7, 32'h7, 1'b0, 1'b0, 32'h3, 32'h5};
        vecs[17] = '{1'b0, 8'h09, 32'h0, 1'b1, 32'h7, 32'h1, 1'b0, 1'b0, 32'h3, 32'h5};
        vecs[18] = '{1'b1, 8'h08, 32'h3, 1'b1, 32'h7, 32'h1, 1'b0, 1'b1, 32'h3, 32'h5};
        vecs[19] = '{1'b0, 8'h09, 32'h0, 1'b0, 32'h7, 32'h0, 1'b0, 1'b0, 32'h3, 32'h5};

        bus.cs = 1'b0; bus.we = 1'b0; bus.address = '0; bus.write_data = '0;
        running = 1'b0; curr_timer = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'h0, bus.ready}, 32'h0);
        chk("rst_read_data", bus.read_data, 32'h0);
        chk("rst_start_stop", {30'h0, start, stop}, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk("rst_prescaler", prescaler_init, 32'h0);
        chk("rst_timer", timer_init, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].run, vecs[i].cur);
            chk($sformatf("v%0d_ready", i), {31'h0, bus.ready}, 32'h1);
            chk($sformatf("v%0d_read_data", i), bus.read_data, vecs[i].rd);
            chk($sformatf("v%0d_start", i), {31'h0, start}, {31'h0, vecs[i].st});
            chk($sformatf("v%0d_stop", i), {31'h0, stop}, {31'h0, vecs[i].sp});
            chk($sformatf("v%0d_prescaler", i), prescaler_init, vecs[i].pre);
            chk($sformatf("v%0d_timer", i), timer_init, vecs[i].tim);
            drop();
            chk($sformatf("v%0d_idle_pulses", i), {29'h0, bus.ready, start, stop}, 32'h0);
        end
        chk("sw_stop_no_irq", {31'h0, irq}, 32'h0);

        // natural expiry after 20 running cycles
        @(negedge clk);
        running = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        running = 1'b0;
        @(posedge clk); #1;
        chk("expiry_irq", {31'h0, irq}, 32'h1);
        access(1'b0, 8'h09, 32'h0, 1'b0, 32'h0);
        chk("expiry_status", bus.read_data, 32'h2);
        drop();
        access(1'b1, 8'h09, 32'h2, 1'b0, 32'h0);
        chk("w1c_irq", {31'h0, irq}, 32'h0);
        drop();

        // set wins over a same-cycle clear
        @(negedge clk);
        running = 1'b1;
        @(posedge clk);
        access(1'b1, 8'h09, 32'h2, 1'b0, 32'h0);
        chk("set_over_clear", {31'h0, irq}, 32'h1);
        drop();
        access(1'b1, 8'h08, 32'h1, 1'b0, 32'h0);
        chk("start_pulse", {31'h0, start}, 32'h1);
        chk("start_clears_irq", {31'h0, irq}, 32'h0);
        drop();

        // expire again, then reset during a pending access
        @(negedge clk);
        running = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        running = 1'b0;
        @(posedge clk); #1;
        chk("pre_reset_irq", {31'h0, irq}, 32'h1);
        access(1'b0, 8'h00, 32'h0, 1'b0, 32'h0);
        reset_n = 1'b0;
        bus.cs = 1'b0;
        #1;
        chk("mid_rst_ready", {31'h0, bus.ready}, 32'h0);
        chk("mid_rst_read_data", bus.read_data, 32'h0);
        chk("mid_rst_irq", {31'h0, irq}, 32'h0);
        chk("mid_rst_prescaler", prescaler_init, 32'h0);
        chk("mid_rst_timer", timer_init, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_no_ready", {31'h0, bus.ready}, 32'h0);
        @(posedge clk); #1;
        chk("post_rst_no_ready2", {31'h0, bus.ready}, 32'h0);
        access(1'b0, 8'h02, 32'h0, 1'b0, 32'h0);
        chk("post_rst_ready", {31'h0, bus.ready}, 32'h1);
        chk("post_rst_version", bus.read_data, 32'h1);
        drop();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
